// File: rtl/zoom_frame_scheduler.sv
// Frame-level sequencer for the 2x2 block-average unit: sweeps the pixel index
// over the output frame, parks the unit between frames and guards it with a watchdog.
module zoom_frame_scheduler #(
   parameter int OUT_W   = 160,
   parameter int OUT_H   = 120,
   parameter int TIMEOUT = 31,
   parameter int AW      = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          unit_done,
   output logic [AW-1:0] unit_addr,
   output logic          busy,
   output logic          frame_done,
   output logic          error,
   output logic [AW-1:0] pixel_count,
   output logic [1:0]    state_dbg
);

   localparam logic [AW-1:0] PARK = AW'(OUT_W * OUT_H);
   localparam logic [AW-1:0] LAST = AW'(OUT_W * OUT_H - 1);
   localparam int            WDW  = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [AW-1:0]   idx, idx_n;
   logic [AW-1:0]   pixel_count_n;
   logic [WDW-1:0]  wd, wd_n;
   logic            busy_n, error_n;

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         pixel_count <= '0;
         wd          <= '0;
         busy        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         pixel_count <= pixel_count_n;
         wd          <= wd_n;
         busy        <= busy_n;
         error       <= error_n;
      end
   end

   always_comb begin
      state_n       = state;
      idx_n         = idx;
      pixel_count_n = pixel_count;
      wd_n          = wd;
      busy_n        = busy;
      error_n       = error;
      unit_addr     = PARK;
      frame_done    = 1'b0;
      case (state)
         IDLE, ERR: begin
            if (start) begin
               state_n       = RUN;
               idx_n         = '0;
               pixel_count_n = '0;
               wd_n          = '0;
               error_n       = 1'b0;
               busy_n        = 1'b1;
            end
         end
         RUN: begin
            // The next index is presented during the done cycle so the unit
            // restarts on the very edge it finishes.
            if (unit_done)
               unit_addr = (idx == LAST) ? PARK : idx + 1'b1;
            else
               unit_addr = idx;
            if (abort) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else if (unit_done) begin
               pixel_count_n = pixel_count + 1'b1;
               wd_n          = '0;
               if (idx == LAST)
                  state_n = DONE;
               else
                  idx_n = idx + 1'b1;
            end else begin
               wd_n = wd + 1'b1;
               if (wd == WD_LIMIT) begin
                  error_n = 1'b1;
                  busy_n  = 1'b0;
                  state_n = ERR;
               end
            end
         end
         DONE: begin
            frame_done = 1'b1;
            busy_n     = 1'b0;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_zoom_frame_scheduler.sv
// Randomized bench for zoom_frame_scheduler on a small 4x2 frame, with a
// variable-latency averaging-unit model and a frame-level reference model.
module tb_zoom_frame_scheduler;

   localparam int OUT_W   = 4;
   localparam int OUT_H   = 2;
   localparam int TIMEOUT = 12;
   localparam int AW      = 17;
   localparam int PARK    = OUT_W * OUT_H;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          unit_done = 1'b0;
   logic [AW-1:0] unit_addr;
   logic          busy, frame_done, error;
   logic [AW-1:0] pixel_count;
   logic [1:0]    state_dbg;

   zoom_frame_scheduler #(
      .OUT_W(OUT_W), .OUT_H(OUT_H), .TIMEOUT(TIMEOUT), .AW(AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .unit_done(unit_done),
      .unit_addr(unit_addr), .busy(busy), .frame_done(frame_done), .error(error),
      .pixel_count(pixel_count), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // reference model: what the sweep should look like from the outside
   bit r_running, r_finishing, r_faulted;
   int r_next, r_count, r_silent;
   logic [AW-1:0] exp_q[$];

   // averaging-unit model
   bit u_busy, u_stall;
   int u_left;
   int stall_idx = -1;
   int accepts = 0;
   int edge_n = 0;
   int issue_edge = 0;
   int fd_seen = 0;
   bit chk_en = 1'b0;

   task automatic unit_reset();
      u_busy  = 1'b0;
      u_stall = 1'b0;
      u_left  = 0;
   endtask

   task automatic step(input bit s, input bit a, input bit r);
      bit ud;
      int nxt, ea;
      ud = u_busy && !u_stall && (u_left == 0);
      if (!u_busy && !r_running && $urandom_range(0, 7) == 0) ud = 1'b1;
      start = s; abort = a; rst = r; unit_done = ud;
      #1;
      if (chk_en) begin
         nxt = r_next + (ud ? 1 : 0);
         ea  = r_running ? ((nxt < PARK) ? nxt : PARK) : PARK;
         check("unit_addr",   unit_addr,   ea);
         check("busy",        busy,        r_running || r_finishing);
         check("frame_done",  frame_done,  r_finishing);
         check("error",       error,       r_faulted);
         check("pixel_count", pixel_count, r_count);
      end
      if (frame_done === 1'b1) fd_seen++;
      // unit: finishes, then may pick up a new index on the same edge
      if (ud && u_busy) u_busy = 1'b0;
      else if (u_busy && u_left > 0) u_left--;
      if (!u_busy && unit_addr < PARK) begin
         u_busy = 1'b1;
         u_left = $urandom_range(0, 3);
         accepts++;
         if (int'(unit_addr) == stall_idx) begin
            u_stall = 1'b1;
            issue_edge = edge_n + 1;
         end
         if (!r_running) check("issue_idle", unit_addr, PARK);
         else if (exp_q.size() == 0) check("issue_extra", unit_addr, PARK);
         else check("issue_order", unit_addr, exp_q.pop_front());
      end
      // reference update at the edge
      if (r) begin
         r_running = 0; r_finishing = 0; r_faulted = 0;
         r_next = 0; r_count = 0; r_silent = 0;
         exp_q.delete();
      end else if (r_finishing) begin
         r_finishing = 0;
      end else if (r_running) begin
         if (a) begin
            r_running = 0;
         end else if (ud) begin
            r_count++;
            r_silent = 0;
            if (r_next == PARK - 1) begin
               r_running = 0;
               r_finishing = 1;
               check("issue_left", exp_q.size(), 0);
            end else begin
               r_next++;
            end
         end else begin
            r_silent++;
            if (r_silent == TIMEOUT) begin
               r_running = 0;
               r_faulted = 1;
            end
         end
      end else if (s) begin
         r_running = 1; r_faulted = 0;
         r_next = 0; r_count = 0; r_silent = 0;
         exp_q.delete();
         for (int i = 0; i < PARK; i++) exp_q.push_back(AW'(i));
      end
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic run_to_idle();
      int budget;
      budget = 400;
      while ((r_running || r_finishing) && budget > 0) begin
         step($urandom_range(0, 5) == 0, 1'b0, 1'b0);
         budget--;
      end
      if (budget == 0) check("sweep_timeout", 1, 0);
   endtask

   task automatic drain();
      int budget;
      budget = 50;
      while (u_busy && !u_stall && budget > 0) begin
         step(1'b0, 1'b0, 1'b0);
         budget--;
      end
      if (budget == 0) check("drain_timeout", 1, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=%0d exp=%0d", edge_n, 0);
      $fatal(1, "bench did not finish");
   end

   initial begin
      int budget, fd0;
      unit_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      step(1'b0, 1'b0, 1'b1);
      check("rst_state", state_dbg, 0);

      // idle: unit must stay parked
      repeat (50) step(1'b0, 1'b0, 1'b0);
      check("idle_issue", accepts, 0);
      check("idle_addr", unit_addr, PARK);

      // full random frames
      repeat (6) begin
         repeat ($urandom_range(0, 5)) step(1'b0, 1'b0, 1'b0);
         fd0 = fd_seen;
         step(1'b1, 1'b0, 1'b0);
         run_to_idle();
         check("frame_count", pixel_count, PARK);
         check("frame_pulses", fd_seen - fd0, 1);
         check("frame_addr", unit_addr, PARK);
      end

      // watchdog: unit hangs on index 3
      stall_idx = 3;
      step(1'b1, 1'b0, 1'b0);
      budget = 200;
      while (error !== 1'b1 && budget > 0) begin
         step(1'b0, 1'b0, 1'b0);
         budget--;
      end
      check("wd_latency", edge_n - issue_edge, TIMEOUT);
      check("wd_count", pixel_count, 3);
      check("wd_addr", unit_addr, PARK);
      check("wd_state", state_dbg, 3);
      step(1'b0, 1'b1, 1'b0);
      check("err_abort_ignored", error, 1);
      stall_idx = -1;
      unit_reset();
      step(1'b1, 1'b0, 1'b0);
      check("err_cleared", error, 0);
      run_to_idle();
      check("err_restart_count", pixel_count, PARK);

      // abort after five completions; the in-flight result is ignored
      fd0 = fd_seen;
      step(1'b1, 1'b0, 1'b0);
      budget = 100;
      while (r_count < 5 && budget > 0) begin
         step(1'b0, 1'b0, 1'b0);
         budget--;
      end
      step(1'b0, 1'b1, 1'b0);
      check("abort_busy", busy, 0);
      check("abort_addr", unit_addr, PARK);
      drain();
      repeat (3) step(1'b0, 1'b0, 1'b0);
      check("abort_count", pixel_count, 5);
      check("abort_no_frame", fd_seen - fd0, 0);

      // start during RUN ignored; start+abort in RUN aborts
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      check("start_in_run_busy", busy, 1);
      step(1'b1, 1'b1, 1'b0);
      check("start_abort_run", busy, 0);
      drain();
      // start+abort in IDLE starts a sweep
      step(1'b1, 1'b1, 1'b0);
      check("start_abort_idle", busy, 1);
      run_to_idle();
      check("start_abort_count", pixel_count, PARK);

      // reset mid-sweep
      step(1'b1, 1'b0, 1'b0);
      budget = 100;
      while (r_next < 5 && budget > 0) begin
         step(1'b0, 1'b0, 1'b0);
         budget--;
      end
      step(1'b0, 1'b0, 1'b1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_addr", unit_addr, PARK);
      check("rst_mid_count", pixel_count, 0);
      check("rst_mid_state", state_dbg, 0);
      drain();
      step(1'b1, 1'b0, 1'b0);
      run_to_idle();
      check("rst_restart_count", pixel_count, PARK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
